// File: rtl/wb_port_arbiter_pkg.sv
// wb_arb_pkg: shared types and constants for the regfile writeback-port
// arbiter.
//   src_e    : requester index, which is also the bit position in req_valid
//              and req_ready.
//   wb_req_t : one writeback request (rd + data) at the default width.
// Optional feature macro: WB_ARB_STALLCNT_EN (used by wb_port_arbiter).
package wb_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    SRC_ALU    = 2'd0,
    SRC_LSU    = 2'd1,
    SRC_MULDIV = 2'd2,
    SRC_CSR    = 2'd3
  } src_e;

  typedef struct packed {
    logic [4:0]          rd;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: bundle for the requester side of the writeback arbiter.
// It carries one valid/ready handshake per requester.
//   req_valid [NREQ]        requester holds a result
//   req_rd    [NREQ][5]     destination register
//   req_data  [NREQ][XLEN]  result data
//   req_ready [NREQ]        one-hot grant from the arbiter
// Modports:
//   master : requesters (execute/commit units)
//   slave  : the arbiter
interface wb_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int XLEN = 32
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][4:0]      req_rd;
  logic [NREQ-1:0][XLEN-1:0] req_data;
  logic [NREQ-1:0]           req_ready;

  modport master (output req_valid, output req_rd, output req_data, input req_ready);
  modport slave  (input  req_valid, input  req_rd, input  req_data, output req_ready);
endinterface

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin priority encoder.
// It scans req starting at index ptr and wraps modulo N. The first set bit
// wins and is returned both one-hot (gnt) and as an index (gnt_idx).
// When req is all zero, gnt is 0 and gnt_idx is 0.
//   req     in  N      request vector
//   ptr     in  IDX_W  highest-priority index this cycle
//   gnt     out N      one-hot grant
//   gnt_idx out IDX_W  index of the granted bit
//   any     out 1      some request was granted
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single integer-regfile write port between the
// ALU, LSU, MULDIV and CSR writeback sources.
// Arbitration is round-robin. The port is driven from a registered stage, so
// a request accepted at edge t is written during cycle t+1.
//   clk, rst        clock and synchronous active-high reset
//   bus (slave)     per-requester valid/rd/data in, one-hot req_ready out
//   flush           pipeline kill: blocks grants this cycle, ptr holds
//   we6/rdaddr6/wb6 registered regfile write port (x0 is never written)
//   busy            some request is valid, or a write is pending on we6
//   stall_cnt       per-requester saturating wait counter
//                   (only with WB_ARB_STALLCNT_EN)
// Optional feature macro: WB_ARB_STALLCNT_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  wb_port_arbiter_if.slave             bus,
  input  logic                         flush,
  output logic                         we6,
  output logic [4:0]                   rdaddr6,
  output logic [XLEN-1:0]              wb6,
`ifdef WB_ARB_STALLCNT_EN
  output logic [NREQ-1:0][CNT_W-1:0]   stall_cnt,
`endif
  output logic                         busy
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             we6_q, we6_d;
  logic [4:0]       rdaddr6_q, rdaddr6_d;
  logic [XLEN-1:0]  wb6_q, wb6_d;

  logic [NREQ-1:0]  gnt_raw;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             accept;
  logic [4:0]       sel_rd;

  rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt_raw),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Ready is a function of valid and ptr only, never of the requester's
  // data. Reset and flush both suppress every grant.
  assign bus.req_ready = (rst || flush) ? '0 : gnt_raw;
  assign accept        = gnt_any && !rst && !flush;
  assign sel_rd        = bus.req_rd[gnt_idx];

  always_comb begin
    ptr_d     = ptr_q;
    we6_d     = 1'b0;
    rdaddr6_d = rdaddr6_q;
    wb6_d     = wb6_q;
    if (accept) begin
      ptr_d     = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      // A request to x0 still completes its handshake but never writes.
      we6_d     = (sel_rd != 5'd0);
      rdaddr6_d = sel_rd;
      wb6_d     = bus.req_data[gnt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      we6_q     <= 1'b0;
      rdaddr6_q <= '0;
      wb6_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      we6_q     <= we6_d;
      rdaddr6_q <= rdaddr6_d;
      wb6_q     <= wb6_d;
    end
  end

  assign we6     = we6_q;
  assign rdaddr6 = rdaddr6_q;
  assign wb6     = wb6_q;
  assign busy    = (|bus.req_valid) || we6_q;

`ifdef WB_ARB_STALLCNT_EN
  logic [NREQ-1:0][CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // A requester counts as waiting when it is valid and not granted. This
  // includes cycles blocked by flush. Each counter saturates at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && !bus.req_ready[i] && !(&stall_cnt_q[i]))
        stall_cnt_d[i] = stall_cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
